// File: rtl/branch_recovery_ctrl_if.sv
// Pipeline-side bundle for the branch-recovery controller: ID/EX/IF inputs and the
// hazard, replay and PC-steering outputs.
interface branch_recovery_ctrl_if;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_Branch;
  logic [29:0] ID_PC;
  logic [31:0] IF_instruction;
  logic        EX_MemtoReg;
  logic        EX_RegWr;
  logic [4:0]  EX_rt;
  logic        EX_Branch;
  logic        EX_taken;
  logic [29:0] EX_PC;
  logic [29:0] EX_tgt;

  logic        Load_use;
  logic        signal;
  logic [31:0] pre_instruction;
  logic        pc_stall;
  logic        ifid_stall;
  logic        ifid_flush;
  logic        redirect;
  logic [29:0] redirect_pc;
  logic        pred_taken;

  modport master (
    output ID_rs, ID_rt, ID_Branch, ID_PC, IF_instruction,
           EX_MemtoReg, EX_RegWr, EX_rt, EX_Branch, EX_taken, EX_PC, EX_tgt,
    input  Load_use, signal, pre_instruction, pc_stall, ifid_stall,
           ifid_flush, redirect, redirect_pc, pred_taken
  );

  modport slave (
    input  ID_rs, ID_rt, ID_Branch, ID_PC, IF_instruction,
           EX_MemtoReg, EX_RegWr, EX_rt, EX_Branch, EX_taken, EX_PC, EX_tgt,
    output Load_use, signal, pre_instruction, pc_stall, ifid_stall,
           ifid_flush, redirect, redirect_pc, pred_taken
  );
endinterface

// File: rtl/branch_recovery_ctrl.sv
// Load-use hazard detection plus 2-bit branch prediction with replay of the squashed
// fall-through instruction when a predicted-taken branch resolves not-taken.
module branch_recovery_ctrl #(
  parameter logic [1:0] CNT_INIT    = 2'b10,
  parameter bit         STATIC_PRED = 1'b0
) (
  input logic                   clk,
  input logic                   rst_n,
  branch_recovery_ctrl_if.slave bus
);

  typedef enum logic {IDLE, RESOLVE} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic        pend_pred;
  logic [31:0] pre_q;
  logic [29:0] br_pc;

  logic        pred;
  logic        lu_raw;
  logic        lu;
  logic        resolving;
  logic        mispredict;
  logic        capture;
  logic [29:0] replay_pc;

  assign pred = STATIC_PRED ? 1'b1 : cnt[1];

  assign lu_raw = bus.EX_MemtoReg & bus.EX_RegWr & (bus.EX_rt != 5'd0) &
                  ((bus.EX_rt == bus.ID_rs) | (bus.EX_rt == bus.ID_rt));

  // Only the branch we captured may resolve; its PC was latched when it left ID.
  assign resolving  = (state == RESOLVE) & bus.EX_Branch & (bus.EX_PC == br_pc);
  assign mispredict = resolving & (pend_pred ^ bus.EX_taken);

  // A resolving mispredict makes the ID instruction wrong-path, so its hazard is moot.
  assign lu = lu_raw & ~mispredict;

  assign capture = bus.ID_Branch & ~lu &
                   ((state == IDLE) | (resolving & ~mispredict));

  // The replayed instruction occupies EX_PC+1, so fetch resumes one word later.
  assign replay_pc = bus.EX_PC + 30'd2;

  assign bus.Load_use        = lu;
  assign bus.pc_stall        = lu;
  assign bus.ifid_stall      = lu;
  assign bus.signal          = mispredict & pend_pred;
  assign bus.ifid_flush      = (capture & pred) | mispredict;
  assign bus.redirect        = (capture & pred) | mispredict;
  // On a predicted-taken capture the target comes from the ID-side adder, not from here.
  assign bus.redirect_pc     = mispredict ? (pend_pred ? replay_pc : bus.EX_tgt) : 30'd0;
  assign bus.pred_taken      = pred;
  assign bus.pre_instruction = pre_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= CNT_INIT;
      pend_pred <= 1'b0;
      pre_q     <= 32'd0;
      br_pc     <= 30'd0;
    end else begin
      if (resolving) begin
        if (bus.EX_taken)
          cnt <= (cnt == 2'b11) ? cnt : cnt + 2'b01;
        else
          cnt <= (cnt == 2'b00) ? cnt : cnt - 2'b01;
      end
      if (capture) begin
        state     <= RESOLVE;
        pend_pred <= pred;
        br_pc     <= bus.ID_PC;
        if (pred)
          pre_q <= bus.IF_instruction;
      end else if (state == RESOLVE) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed scoreboard bench for branch_recovery_ctrl: load-use, replay, redirect,
// back-to-back branches, counter saturation and mid-resolve reset.
module tb_branch_recovery_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  branch_recovery_ctrl_if bus();

  branch_recovery_ctrl #(
    .CNT_INIT    (2'b10),
    .STATIC_PRED (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        lu;
    logic        sig;
    logic        flush;
    logic        pred;
    logic [29:0] rpc;
    logic [31:0] pre;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic exp_t mk(input logic lu, input logic sig, input logic flush,
                              input logic pred, input logic [29:0] rpc,
                              input logic [31:0] pre);
    exp_t e;
    e.lu    = lu;
    e.sig   = sig;
    e.flush = flush;
    e.pred  = pred;
    e.rpc   = rpc;
    e.pre   = pre;
    return e;
  endfunction

  task automatic clearInputs();
    bus.ID_rs          = 5'd0;
    bus.ID_rt          = 5'd0;
    bus.ID_Branch      = 1'b0;
    bus.ID_PC          = 30'd0;
    bus.IF_instruction = 32'd0;
    bus.EX_MemtoReg    = 1'b0;
    bus.EX_RegWr       = 1'b0;
    bus.EX_rt          = 5'd0;
    bus.EX_Branch      = 1'b0;
    bus.EX_taken       = 1'b0;
    bus.EX_PC          = 30'd0;
    bus.EX_tgt         = 30'd0;
  endtask

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s.%s observed=0x%0h expected=0x%0h", tag, field, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t  e;
    string tag;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      tag = tag_q.pop_front();
      cmp(tag, "Load_use",        32'(bus.Load_use),    32'(e.lu));
      cmp(tag, "pc_stall",        32'(bus.pc_stall),    32'(e.lu));
      cmp(tag, "ifid_stall",      32'(bus.ifid_stall),  32'(e.lu));
      cmp(tag, "signal",          32'(bus.signal),      32'(e.sig));
      cmp(tag, "ifid_flush",      32'(bus.ifid_flush),  32'(e.flush));
      cmp(tag, "redirect",        32'(bus.redirect),    32'(e.flush));
      cmp(tag, "redirect_pc",     32'(bus.redirect_pc), 32'(e.rpc));
      cmp(tag, "pred_taken",      32'(bus.pred_taken),  32'(e.pred));
      cmp(tag, "pre_instruction", bus.pre_instruction,  e.pre);
    end
  endtask

  // Inputs are already driven by the caller; record what the DUT must show, then sample.
  task automatic applyStimulus(input string tag, input exp_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    checkOutput();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearInputs();
    repeat (2) @(posedge clk);
    applyStimulus("reset", mk(0, 0, 0, 1, 30'h0, 32'h0));
    @(posedge clk);
    rst_n = 1'b1;

    // Load-use detection
    @(posedge clk); clearInputs();
    bus.EX_MemtoReg = 1; bus.EX_RegWr = 1; bus.EX_rt = 5'd1; bus.ID_rs = 5'd1; bus.ID_rt = 5'd2;
    applyStimulus("lu_rs", mk(1, 0, 0, 1, 30'h0, 32'h0));
    @(posedge clk); clearInputs(); bus.ID_rs = 5'd1;
    applyStimulus("lu_clear", mk(0, 0, 0, 1, 30'h0, 32'h0));
    @(posedge clk); clearInputs();
    bus.EX_MemtoReg = 1; bus.EX_RegWr = 1; bus.EX_rt = 5'd5; bus.ID_rt = 5'd5;
    applyStimulus("lu_rt", mk(1, 0, 0, 1, 30'h0, 32'h0));
    @(posedge clk); clearInputs();
    bus.EX_MemtoReg = 1; bus.EX_RegWr = 0; bus.EX_rt = 5'd5; bus.ID_rt = 5'd5;
    applyStimulus("lu_nowr", mk(0, 0, 0, 1, 30'h0, 32'h0));
    @(posedge clk); clearInputs();
    bus.EX_MemtoReg = 1; bus.EX_RegWr = 1; bus.EX_rt = 5'd0; bus.ID_rs = 5'd0;
    applyStimulus("lu_r0", mk(0, 0, 0, 1, 30'h0, 32'h0));

    // Predicted-taken branch held by load-use, then captured and mispredicted
    @(posedge clk); clearInputs();
    bus.EX_MemtoReg = 1; bus.EX_RegWr = 1; bus.EX_rt = 5'd4; bus.ID_rs = 5'd4;
    bus.ID_Branch = 1; bus.ID_PC = 30'h10; bus.IF_instruction = 32'h2002000A;
    applyStimulus("br_held", mk(1, 0, 0, 1, 30'h0, 32'h0));
    @(posedge clk); clearInputs();
    bus.ID_Branch = 1; bus.ID_PC = 30'h10; bus.IF_instruction = 32'h2002000A;
    applyStimulus("br_capture", mk(0, 0, 1, 1, 30'h0, 32'h0));
    @(posedge clk); clearInputs();
    bus.EX_Branch = 1; bus.EX_taken = 0; bus.EX_PC = 30'h10; bus.EX_tgt = 30'h99;
    bus.EX_MemtoReg = 1; bus.EX_RegWr = 1; bus.EX_rt = 5'd3; bus.ID_rs = 5'd3;
    applyStimulus("br_mispredict", mk(0, 1, 1, 1, 30'h12, 32'h2002000A));
    @(posedge clk); clearInputs();
    applyStimulus("after_replay", mk(0, 0, 0, 0, 30'h0, 32'h2002000A));

    // Predicted not-taken, resolves taken
    @(posedge clk); clearInputs();
    bus.ID_Branch = 1; bus.ID_PC = 30'h20; bus.IF_instruction = 32'h11111111;
    applyStimulus("nt_capture", mk(0, 0, 0, 0, 30'h0, 32'h2002000A));
    @(posedge clk); clearInputs();
    bus.EX_Branch = 1; bus.EX_taken = 1; bus.EX_PC = 30'h20; bus.EX_tgt = 30'h40;
    applyStimulus("nt_resolve_taken", mk(0, 0, 1, 0, 30'h40, 32'h2002000A));
    @(posedge clk); clearInputs();
    applyStimulus("cnt_up", mk(0, 0, 0, 1, 30'h0, 32'h2002000A));

    // Replay PC wraps modulo 2^30
    @(posedge clk); clearInputs();
    bus.ID_Branch = 1; bus.ID_PC = 30'h3FFFFFFF; bus.IF_instruction = 32'h12345678;
    applyStimulus("wrap_capture", mk(0, 0, 1, 1, 30'h0, 32'h2002000A));
    @(posedge clk); clearInputs();
    bus.EX_Branch = 1; bus.EX_taken = 0; bus.EX_PC = 30'h3FFFFFFF; bus.EX_tgt = 30'h5;
    applyStimulus("wrap_replay", mk(0, 1, 1, 1, 30'h1, 32'h12345678));
    @(posedge clk); clearInputs();
    bus.ID_Branch = 1; bus.ID_PC = 30'h30; bus.IF_instruction = 32'h22222222;
    applyStimulus("nt2_capture", mk(0, 0, 0, 0, 30'h0, 32'h12345678));
    @(posedge clk); clearInputs();
    bus.EX_Branch = 1; bus.EX_taken = 1; bus.EX_PC = 30'h30; bus.EX_tgt = 30'h3FFFFFFF;
    applyStimulus("nt2_taken", mk(0, 0, 1, 0, 30'h3FFFFFFF, 32'h12345678));

    // Back-to-back taken branches, counter saturates at 3
    @(posedge clk); clearInputs();
    bus.ID_Branch = 1; bus.ID_PC = 30'h50; bus.IF_instruction = 32'hAAAA0001;
    applyStimulus("b2b_first", mk(0, 0, 1, 1, 30'h0, 32'h12345678));
    @(posedge clk); clearInputs();
    bus.EX_Branch = 1; bus.EX_taken = 1; bus.EX_PC = 30'h50; bus.EX_tgt = 30'h60;
    bus.ID_Branch = 1; bus.ID_PC = 30'h60; bus.IF_instruction = 32'hBBBB0002;
    applyStimulus("b2b_second", mk(0, 0, 1, 1, 30'h0, 32'hAAAA0001));
    @(posedge clk); clearInputs();
    bus.EX_Branch = 1; bus.EX_taken = 1; bus.EX_PC = 30'h60; bus.EX_tgt = 30'h70;
    applyStimulus("b2b_resolve", mk(0, 0, 0, 1, 30'h0, 32'hBBBB0002));
    @(posedge clk); clearInputs();
    applyStimulus("sat_check", mk(0, 0, 0, 1, 30'h0, 32'hBBBB0002));

    // Reset while a predicted-taken branch is resolving
    @(posedge clk); clearInputs();
    bus.ID_Branch = 1; bus.ID_PC = 30'h80; bus.IF_instruction = 32'hDEADBEEF;
    applyStimulus("rst_capture", mk(0, 0, 1, 1, 30'h0, 32'hBBBB0002));
    @(posedge clk); clearInputs();
    bus.EX_Branch = 1; bus.EX_taken = 0; bus.EX_PC = 30'h80;
    rst_n = 1'b0;
    applyStimulus("rst_mid", mk(0, 0, 0, 1, 30'h0, 32'h0));
    @(posedge clk);
    rst_n = 1'b1;
    applyStimulus("rst_noreplay", mk(0, 0, 0, 1, 30'h0, 32'h0));
    @(posedge clk); clearInputs();
    bus.ID_Branch = 1; bus.ID_PC = 30'h90; bus.IF_instruction = 32'hCAFE0003;
    applyStimulus("post_capture", mk(0, 0, 1, 1, 30'h0, 32'h0));
    @(posedge clk); clearInputs();
    bus.EX_Branch = 1; bus.EX_taken = 0; bus.EX_PC = 30'h90;
    applyStimulus("post_mispredict", mk(0, 1, 1, 1, 30'h92, 32'hCAFE0003));
    @(posedge clk); clearInputs();
    applyStimulus("post_cnt", mk(0, 0, 0, 0, 30'h0, 32'hCAFE0003));

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
